scan_port_arb: RTL and testbench

Two-requester arbiter for the single scan-side memory/register access port (the `scan_*` port into mem_reg_mux).
- Owns the downstream port and grants it to requester A or B with round-robin fairness.
- Issues each granted access as a one-cycle command pulse, then waits for `scan_ready` or a timeout.
- Returns read data, a completion pulse and an error flag to the winning requester.

---
 rtl/scan_port_arb.sv | 182 ++++++++++++++++++
 tb/tb_scan_port_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_port_arb.sv
// Round-robin arbiter giving requesters A and B turns on the single scan access port.
// Each access: one-cycle command pulse, wait for scan_ready or timeout, one-cycle completion.
module scan_port_arb #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_wen,
  input  logic        a_ren,
  input  logic [11:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_wen,
  input  logic        b_ren,
  input  logic [11:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        scan_wen,
  output logic        scan_ren,
  output logic [11:0] scan_addr,
  output logic [31:0] scan_wdata,
  input  logic [31:0] scan_rdata,
  input  logic        scan_ready,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COOL} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;        // 1 = B owns the current access
  logic          last_b_q, last_b_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          scan_wen_q, scan_wen_d;
  logic          scan_ren_q, scan_ren_d;
  logic [11:0]   scan_addr_q, scan_addr_d;
  logic [31:0]   scan_wdata_q, scan_wdata_d;
  logic          a_ready_q, a_ready_d;
  logic          b_ready_q, b_ready_d;
  logic          a_err_q, a_err_d;
  logic          b_err_q, b_err_d;
  logic [31:0]   a_rdata_q, a_rdata_d;
  logic [31:0]   b_rdata_q, b_rdata_d;
  logic          busy_q, busy_d;

  logic          a_pend, b_pend;
  logic          done, timed_out;
  logic [31:0]   rd_val;

  assign a_pend = a_wen | a_ren;
  assign b_pend = b_wen | b_ren;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_b_d     = last_b_q;
    cmd_wr_d     = cmd_wr_q;
    cnt_d        = cnt_q;
    scan_wen_d   = 1'b0;
    scan_ren_d   = 1'b0;
    scan_addr_d  = '0;
    scan_wdata_d = '0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    done         = 1'b0;
    timed_out    = 1'b0;
    rd_val       = scan_rdata;

    case (state_q)
      IDLE: begin
        // A wins a tie only when B had the previous turn.
        if (a_pend && (!b_pend || last_b_q)) begin
          grant_d      = 1'b0;
          last_b_d     = 1'b0;
          cmd_wr_d     = a_wen;
          scan_wen_d   = a_wen;
          scan_ren_d   = ~a_wen;
          scan_addr_d  = a_addr;
          scan_wdata_d = a_wdata;
          state_d      = ISSUE;
        end else if (b_pend) begin
          grant_d      = 1'b1;
          last_b_d     = 1'b1;
          cmd_wr_d     = b_wen;
          scan_wen_d   = b_wen;
          scan_ren_d   = ~b_wen;
          scan_addr_d  = b_addr;
          scan_wdata_d = b_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (scan_ready) begin
          done    = 1'b1;
          state_d = COOL;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          rd_val    = ERR_DATA;
          state_d   = COOL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done && !cmd_wr_q) begin
          if (grant_q) b_rdata_d = rd_val;
          else         a_rdata_d = rd_val;
        end
      end
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    a_ready_d = done & ~grant_q;
    b_ready_d = done & grant_q;
    a_err_d   = timed_out & ~grant_q;
    b_err_d   = timed_out & grant_q;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_b_q     <= 1'b1;
      cmd_wr_q     <= 1'b0;
      cnt_q        <= '0;
      scan_wen_q   <= 1'b0;
      scan_ren_q   <= 1'b0;
      scan_addr_q  <= '0;
      scan_wdata_q <= '0;
      a_ready_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_b_q     <= last_b_d;
      cmd_wr_q     <= cmd_wr_d;
      cnt_q        <= cnt_d;
      scan_wen_q   <= scan_wen_d;
      scan_ren_q   <= scan_ren_d;
      scan_addr_q  <= scan_addr_d;
      scan_wdata_q <= scan_wdata_d;
      a_ready_q    <= a_ready_d;
      b_ready_q    <= b_ready_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign scan_wen   = scan_wen_q;
  assign scan_ren   = scan_ren_q;
  assign scan_addr  = scan_addr_q;
  assign scan_wdata = scan_wdata_q;
  assign a_ready    = a_ready_q;
  assign b_ready    = b_ready_q;
  assign a_err      = a_err_q;
  assign b_err      = b_err_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_port_arb.sv
// Randomised scoreboard bench for scan_port_arb: stimulus queues expectations, monitor checks.
module tb_scan_port_arb;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  logic a_wen, a_ren, b_wen, b_ren;
  logic [11:0] a_addr, b_addr, scan_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, scan_wdata, scan_rdata;
  logic a_ready, a_err, b_ready, b_err;
  logic scan_wen, scan_ren, scan_ready, busy;

  always #5 clk = ~clk;

  scan_port_arb #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wen(a_wen), .a_ren(a_ren), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_err(a_err),
    .b_wen(b_wen), .b_ren(b_ren), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_err(b_err),
    .scan_wen(scan_wen), .scan_ren(scan_ren), .scan_addr(scan_addr),
    .scan_wdata(scan_wdata), .scan_rdata(scan_rdata), .scan_ready(scan_ready),
    .busy(busy)
  );

  typedef struct { logic wr; logic [11:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { logic port; logic err; logic [31:0] rdata; int delta; } done_t;
  typedef struct { int delay; logic [31:0] data; } resp_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];
  resp_t resp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int spur_cnt = 0;
  int spur_done = 0;
  logic [31:0] model_rd [2];
  logic        model_last_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_scan_cmd"}, 32'({scan_wen, scan_ren}), 32'd0);
    check({tag, "_scan_addr"}, 32'(scan_addr), 32'd0);
    check({tag, "_scan_wdata"}, scan_wdata, 32'd0);
    check({tag, "_ready_err"}, 32'({a_ready, a_err, b_ready, b_err}), 32'd0);
    check({tag, "_a_rdata"}, a_rdata, 32'd0);
    check({tag, "_b_rdata"}, b_rdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream responder: answers each command pulse after its scripted delay.
  initial begin : responder
    int cd;
    logic [31:0] pend;
    resp_t r;
    cd = 0;
    pend = '0;
    scan_ready = 1'b0;
    scan_rdata = '0;
    forever begin
      @(negedge clk);
      scan_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          scan_ready = 1'b1;
          scan_rdata = pend;
        end
      end else if (spur_done != spur_cnt) begin
        spur_done++;
        scan_ready = 1'b1;
        scan_rdata = $urandom;
      end
      if ((scan_wen || scan_ren) && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        cd = (r.delay < 0) ? 0 : r.delay + 1;
        pend = r.data;
      end
    end
  end

  initial begin : monitor
    int last_pulse;
    cmd_t c;
    done_t d;
    logic port;
    last_pulse = -100;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      if (scan_wen || scan_ren) begin
        if (exp_cmd_q.size() == 0) fail_event("unexpected_cmd");
        else begin
          c = exp_cmd_q.pop_front();
          check("cmd_wen", 32'(scan_wen), 32'(c.wr));
          check("cmd_ren", 32'(scan_ren), 32'(!c.wr));
          check("cmd_addr", 32'(scan_addr), 32'(c.addr));
          check("cmd_wdata", scan_wdata, c.wdata);
          check("busy_issue", 32'(busy), 32'd1);
        end
        check("pulse_gap_ge4", 32'((cyc - last_pulse) >= 4), 32'd1);
        last_pulse = cyc;
      end else if (scan_addr != 12'd0 || scan_wdata != 32'd0) begin
        fail_event("scan_bus_not_zero");
      end
      if (a_ready && b_ready) fail_event("both_ready");
      else if (a_ready || b_ready) begin
        if (exp_done_q.size() == 0) fail_event("unexpected_ready");
        else begin
          d = exp_done_q.pop_front();
          port = b_ready;
          check("ready_port", 32'(port), 32'(d.port));
          check("ready_err", 32'(port ? b_err : a_err), 32'(d.err));
          check("ready_rdata", port ? b_rdata : a_rdata, d.rdata);
          check("ready_latency", 32'(cyc - last_pulse), 32'(d.delta));
          check("busy_cool", 32'(busy), 32'd1);
        end
      end else if (a_err || b_err) begin
        fail_event("err_without_ready");
      end
    end
  end

  // Reference: queue the expected command and completion for one granted access.
  task automatic expect_txn(input logic port, input int op, input logic [11:0] addr,
                            input logic [31:0] wd, input int d, input logic [31:0] rdat);
    logic wr, err;
    logic [31:0] r;
    wr  = (op != 0);
    err = (d < 0) || (d >= TO);
    exp_cmd_q.push_back('{wr, addr, wd});
    resp_q.push_back('{d, rdat});
    if (wr) r = model_rd[port];
    else begin
      r = err ? ERRD : rdat;
      model_rd[port] = r;
    end
    exp_done_q.push_back('{port, err, r, err ? TO + 1 : d + 2});
    model_last_b = port;
  endtask

  // op: 0 read, 1 write, 2 write+read both high
  task automatic run_round(input bit ua, input bit ub, input int opa, input int opb,
                           input logic [11:0] adra, input logic [11:0] adrb,
                           input logic [31:0] wda, input logic [31:0] wdb,
                           input int da, input int db,
                           input logic [31:0] rda, input logic [31:0] rdb);
    bit first_b, got_a, got_b;
    first_b = (ua && ub) ? !model_last_b : ub;
    for (int i = 0; i < 2; i++) begin
      logic p;
      p = (i == 0) ? first_b : !first_b;
      if (!p && ua) expect_txn(1'b0, opa, adra, wda, da, rda);
      if (p && ub)  expect_txn(1'b1, opb, adrb, wdb, db, rdb);
    end
    a_addr = adra; a_wdata = wda; b_addr = adrb; b_wdata = wdb;
    a_wen = ua && (opa != 0); a_ren = ua && (opa != 1);
    b_wen = ub && (opb != 0); b_ren = ub && (opb != 1);
    got_a = !ua;
    got_b = !ub;
    for (int k = 0; k < 200 && !(got_a && got_b); k++) begin
      @(negedge clk);
      if (a_ready) begin got_a = 1'b1; a_wen = 1'b0; a_ren = 1'b0; end
      if (b_ready) begin got_b = 1'b1; b_wen = 1'b0; b_ren = 1'b0; end
    end
    if (!(got_a && got_b)) begin
      fail_event("round_no_completion");
      a_wen = 1'b0; a_ren = 1'b0; b_wen = 1'b0; b_ren = 1'b0;
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    bit seen;
    rst_n = 1'b0;
    a_wen = 0; a_ren = 0; b_wen = 0; b_ren = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    model_rd[0] = '0; model_rd[1] = '0;
    model_last_b = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_round(1, 0, 0, 0, 12'h010, 12'h0, 32'h0, 32'h0, 1, 0, 32'h1234_5678, 32'h0);
    run_round(0, 1, 0, 0, 12'h0, 12'h0B0, 32'h0, 32'h0, 0, -1, 32'h0, 32'h5555_AAAA);
    spur_cnt++;
    repeat (3) @(negedge clk);
    run_round(1, 0, 2, 0, 12'h020, 12'h0, 32'hCAFE_0001, 32'h0, 0, 0, 32'h7777_7777, 32'h0);
    run_round(0, 1, 0, 0, 12'h0, 12'h0C4, 32'h0, 32'h0, 0, TO - 1, 32'h0, 32'hA5A5_0007);

    // Abandoned access: reset lands while waiting for scan_ready.
    exp_cmd_q.push_back('{1'b0, 12'h333, 32'h0});
    resp_q.push_back('{-1, 32'h0});
    a_addr = 12'h333; a_wdata = 32'h0; a_ren = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = scan_ren;
    end
    if (!seen) fail_event("reset_case_no_pulse");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    a_ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("mid_reset");
    model_rd[0] = '0; model_rd[1] = '0;
    model_last_b = 1'b1;
    spur_cnt++;
    repeat (TO + 4) @(negedge clk);

    for (int i = 0; i < 2; i++)
      run_round(1, 1, 0, 0, 12'(i), 12'(i + 16), 32'h0, 32'h0, 0, 0,
                32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));

    for (int i = 0; i < 40; i++) begin
      int sel, da, db;
      sel = $urandom_range(1, 3);
      da = $urandom_range(0, TO + 1);
      db = $urandom_range(0, TO + 1);
      if (da == TO + 1) da = -1;
      if (db == TO + 1) db = -1;
      run_round(sel[0], sel[1], $urandom_range(0, 2), $urandom_range(0, 2),
                12'($urandom), 12'($urandom), $urandom, $urandom, da, db, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
